// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: opcode encoding and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// The first iteration happens on the start edge, so done fires WIDTH-1 cycles later.
module alu_shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  // acc holds {partial sum, remaining multiplier bits}; add then shift right.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc,
                                              input logic [WIDTH-1:0]   mc);
    logic [WIDTH:0] upper;
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
    return {upper, acc[WIDTH-1:1]};
  endfunction

  assign product = step(acc_q, mcand_q);
  assign done    = (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      mcand_q <= a;
      acc_q   <= step({{WIDTH{1'b0}}, b}, a);
      cnt_q   <= CNT_LOAD;
    end else if (cnt_q != '0) begin
      acc_q   <= product;
      cnt_q   <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// ALU with valid/ready handshake: single-cycle logic/arith ops, iterative MUL.
// state   | meaning
// IDLE    | ready for a new operation
// MUL     | multiplier iterating, inputs blocked
// DONE    | result held until out_ready
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  import alu_pkg::*;

  localparam int SW = $clog2(WIDTH);

  alu_state_t state_q, state_d;
  alu_op_t    op;
  logic       accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff, res;
  logic             carry_in, res_cout, res_ovf;

  assign op        = alu_op_t'(ctrl);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  always_comb begin
    b_eff    = (op == OP_SUB) ? ~b : b;
    carry_in = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? cin : 1'b0);
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    res      = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b[SW-1:0];
      OP_SHR:  res = a >> b[SW-1:0];
      default: res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (op == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= '0;
      hi_out  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept && (op != OP_MUL)) begin
      alu_out <= res;
      hi_out  <= '0;
      cout    <= res_cout;
      zero    <= (res == '0);
      neg     <= res[WIDTH-1];
      ovf     <= res_ovf;
    end else if ((state_q == ST_MUL) && mul_done) begin
      alu_out <= product[WIDTH-1:0];
      hi_out  <= product[2*WIDTH-1:WIDTH];
      cout    <= 1'b0;
      zero    <= (product == '0);
      neg     <= product[2*WIDTH-1];
      ovf     <= 1'b0;
    end
  end

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

endmodule
